// File: rtl/binary_to_bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package binary_to_bcd_seq_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/binary_to_bcd_seq_if.sv
// Start/done handshake and result bus between the converter and its user.
interface binary_to_bcd_seq_if
  import binary_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                          start;
  logic [WIDTH-1:0]              bin;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]             digit_valid;
  logic                          overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, digit_valid, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, digit_valid, overflow
  );

endinterface

// File: rtl/binary_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import binary_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, with overflow
// detection and a leading-zero blanking mask for the display driver.
module binary_to_bcd_seq
  import binary_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
)(
  input  logic                clk,
  input  logic                rst_n,
  binary_to_bcd_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SCR_W = BCD_DIGIT_W * DIGITS;

  state_t            state, next_state;
  logic              accept, last;
  logic [CNT_W-1:0]  count;
  logic [WIDTH-1:0]  shreg;
  logic [SCR_W-1:0]  scratch, adjusted, shifted;
  logic              ovf_scr, ovf_next;
  logic [DIGITS-1:0] vld_next;
  logic [SCR_W-1:0]  bcd_q;
  logic [DIGITS-1:0] vld_q;
  logic              ovf_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adjusted[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // A 1 leaving the top digit's MSB means the value needs more digits than we have.
  assign shifted  = {adjusted[SCR_W-2:0], shreg[WIDTH-1]};
  assign ovf_next = ovf_scr | adjusted[SCR_W-1];

  always_comb begin
    vld_next = '0;
    vld_next[DIGITS-1] = |shifted[SCR_W-1 -: BCD_DIGIT_W];
    for (int i = DIGITS - 2; i >= 0; i--) begin
      vld_next[i] = vld_next[i+1] | (|shifted[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
    vld_next[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (count == CNT_W'(1)) begin
          last       = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Results are only written on the final shift so the display never sees partial digits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      shreg   <= '0;
      scratch <= '0;
      ovf_scr <= 1'b0;
      bcd_q   <= '0;
      vld_q   <= DIGITS'(1);
      ovf_q   <= 1'b0;
    end else if (accept) begin
      count   <= CNT_W'(WIDTH);
      shreg   <= bus.bin;
      scratch <= '0;
      ovf_scr <= 1'b0;
    end else if (state == SHIFT) begin
      count   <= count - CNT_W'(1);
      shreg   <= shreg << 1;
      scratch <= shifted;
      ovf_scr <= ovf_next;
      if (last) begin
        bcd_q <= shifted;
        vld_q <= vld_next;
        ovf_q <= ovf_next;
      end
    end
  end

  assign bus.busy        = (state == SHIFT);
  assign bus.done        = (state == DONE);
  assign bus.bcd         = bcd_q;
  assign bus.digit_valid = vld_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq in three sizes: 8b/3 digits, 8b/2 digits, 16b/5 digits.
module tb_binary_to_bcd_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  binary_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) a8 ();
  binary_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(2)) a2 ();
  binary_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) a16 ();

  binary_to_bcd_seq #(.WIDTH(8),  .DIGITS(3)) u8  (.clk(clk), .rst_n(rst_n), .bus(a8));
  binary_to_bcd_seq #(.WIDTH(8),  .DIGITS(2)) u2  (.clk(clk), .rst_n(rst_n), .bus(a2));
  binary_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u16 (.clk(clk), .rst_n(rst_n), .bus(a16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency is the number of edges after the accepting edge until done is seen.
  task automatic conv8(input logic [7:0] v, output logic [11:0] b, output logic [2:0] dv,
                       output logic ov, output int lat, output int nbusy);
    @(posedge clk); #1 a8.bin = v; a8.start = 1'b1;
    @(posedge clk); #1 a8.start = 1'b0;
    lat = 0;
    nbusy = int'(a8.busy);
    while (!a8.done && lat < 50) begin
      @(posedge clk); #1 lat++;
      nbusy += int'(a8.busy);
    end
    b = a8.bcd; dv = a8.digit_valid; ov = a8.overflow;
  endtask

  task automatic conv2(input logic [7:0] v, output logic [7:0] b, output logic [1:0] dv,
                       output logic ov, output int lat);
    @(posedge clk); #1 a2.bin = v; a2.start = 1'b1;
    @(posedge clk); #1 a2.start = 1'b0;
    lat = 0;
    while (!a2.done && lat < 50) begin
      @(posedge clk); #1 lat++;
    end
    b = a2.bcd; dv = a2.digit_valid; ov = a2.overflow;
  endtask

  task automatic conv16(input logic [15:0] v, output logic [19:0] b, output logic [4:0] dv,
                        output logic ov, output int lat);
    @(posedge clk); #1 a16.bin = v; a16.start = 1'b1;
    @(posedge clk); #1 a16.start = 1'b0;
    lat = 0;
    while (!a16.done && lat < 50) begin
      @(posedge clk); #1 lat++;
    end
    b = a16.bcd; dv = a16.digit_valid; ov = a16.overflow;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a8.start = 1'b0;  a8.bin = '0;
    a2.start = 1'b0;  a2.bin = '0;
    a16.start = 1'b0; a16.bin = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({a8.busy, a8.done, a8.bcd, a8.digit_valid, a8.overflow} !== {1'b0, 1'b0, 12'h000, 3'b001, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset8 got busy=%b done=%b bcd=%h dv=%b ov=%b exp 0 0 000 001 0",
               a8.busy, a8.done, a8.bcd, a8.digit_valid, a8.overflow);
    end
    total++;
    if ({a16.busy, a16.done, a16.bcd, a16.digit_valid, a16.overflow} !== {1'b0, 1'b0, 20'h00000, 5'b00001, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset16 got busy=%b done=%b bcd=%h dv=%b ov=%b exp 0 0 00000 00001 0",
               a16.busy, a16.done, a16.bcd, a16.digit_valid, a16.overflow);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0]  vin [4] = '{8'd255, 8'd0, 8'd99, 8'd9};
    logic [11:0] eb  [4] = '{12'h255, 12'h000, 12'h099, 12'h009};
    logic [2:0]  edv [4] = '{3'b111, 3'b001, 3'b011, 3'b001};
    logic [11:0] b; logic [2:0] dv; logic ov; int lat; int nb;
    for (int i = 0; i < 4; i++) begin
      conv8(vin[i], b, dv, ov, lat, nb);
      total++;
      if (b !== eb[i] || dv !== edv[i] || ov !== 1'b0 || lat != 8 || nb != 8) begin
        bad++;
        $display("[TB] FAIL basic v=%0d got bcd=%h dv=%b ov=%b lat=%0d busy=%0d exp bcd=%h dv=%b ov=0 lat=8 busy=8",
                 vin[i], b, dv, ov, lat, nb, eb[i], edv[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b; logic [1:0] dv; logic ov; int lat;
    conv2(8'd200, b, dv, ov, lat);
    total++;
    if (b !== 8'h00 || dv !== 2'b01 || ov !== 1'b1 || lat != 8) begin
      bad++;
      $display("[TB] FAIL ovf200 got bcd=%h dv=%b ov=%b lat=%0d exp bcd=00 dv=01 ov=1 lat=8", b, dv, ov, lat);
    end
    conv2(8'd99, b, dv, ov, lat);
    total++;
    if (b !== 8'h99 || dv !== 2'b11 || ov !== 1'b0 || lat != 8) begin
      bad++;
      $display("[TB] FAIL ovf99 got bcd=%h dv=%b ov=%b lat=%0d exp bcd=99 dv=11 ov=0 lat=8", b, dv, ov, lat);
    end
  endtask

  task automatic test_back_to_back();
    int nd, d1, d2, overlap;
    logic [11:0] r1, r2, mid;
    nd = 0; d1 = -1; d2 = -1; overlap = 0;
    r1 = 'x; r2 = 'x; mid = 'x;
    @(posedge clk); #1 a8.bin = 8'd17; a8.start = 1'b1;
    @(posedge clk); #1 a8.bin = 8'd42;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (a8.done && a8.busy) overlap++;
      if (a8.done) begin
        if (nd == 0) begin d1 = e; r1 = a8.bcd; end
        else if (nd == 1) begin d2 = e; r2 = a8.bcd; end
        nd++;
      end
      if (nd == 1 && a8.busy) begin
        a8.start = 1'b0;
        mid = a8.bcd;
      end
    end
    a8.start = 1'b0;
    total++;
    if (nd != 2 || d1 != 8 || d2 != 17) begin
      bad++;
      $display("[TB] FAIL b2b_timing got dones=%0d at %0d,%0d exp dones=2 at 8,17", nd, d1, d2);
    end
    total++;
    if (r1 !== 12'h017 || r2 !== 12'h042) begin
      bad++;
      $display("[TB] FAIL b2b_data got %h,%h exp 017,042", r1, r2);
    end
    total++;
    if (mid !== 12'h017) begin
      bad++;
      $display("[TB] FAIL b2b_hold got bcd during shift=%h exp 017", mid);
    end
    total++;
    if (overlap != 0) begin
      bad++;
      $display("[TB] FAIL done_busy_overlap got %0d cycles exp 0", overlap);
    end
  endtask

  task automatic test_ignore_start();
    int lat, extra;
    @(posedge clk); #1 a8.bin = 8'd5; a8.start = 1'b1;
    @(posedge clk); #1 a8.start = 1'b0; a8.bin = 8'd77;
    lat = 0;
    repeat (3) begin @(posedge clk); #1 lat++; end
    a8.start = 1'b1;
    @(posedge clk); #1 lat++; a8.start = 1'b0;
    while (!a8.done && lat < 50) begin
      @(posedge clk); #1 lat++;
    end
    total++;
    if (a8.bcd !== 12'h005 || lat != 8) begin
      bad++;
      $display("[TB] FAIL ignore_start got bcd=%h lat=%0d exp bcd=005 lat=8", a8.bcd, lat);
    end
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (a8.done || a8.busy) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("[TB] FAIL ignore_extra got %0d active cycles exp 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int nd, lat, nb;
    logic [11:0] b; logic [2:0] dv; logic ov;
    @(posedge clk); #1 a8.bin = 8'd123; a8.start = 1'b1;
    @(posedge clk); #1 a8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (a8.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrst_busy got %b exp 1", a8.busy);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({a8.busy, a8.done, a8.bcd, a8.digit_valid, a8.overflow} !== {1'b0, 1'b0, 12'h000, 3'b001, 1'b0}) begin
      bad++;
      $display("[TB] FAIL midrst_state got busy=%b done=%b bcd=%h dv=%b ov=%b exp 0 0 000 001 0",
               a8.busy, a8.done, a8.bcd, a8.digit_valid, a8.overflow);
    end
    rst_n = 1'b1;
    nd = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (a8.done) nd++;
    end
    total++;
    if (nd != 0) begin
      bad++;
      $display("[TB] FAIL midrst_nodone got %0d dones exp 0", nd);
    end
    conv8(8'd123, b, dv, ov, lat, nb);
    total++;
    if (b !== 12'h123 || dv !== 3'b111 || ov !== 1'b0 || lat != 8) begin
      bad++;
      $display("[TB] FAIL midrst_fresh got bcd=%h dv=%b ov=%b lat=%0d exp 123 111 0 8", b, dv, ov, lat);
    end
  endtask

  task automatic test_wide();
    logic [15:0] vin [3] = '{16'd65535, 16'd1000, 16'd7};
    logic [19:0] eb  [3] = '{20'h65535, 20'h01000, 20'h00007};
    logic [4:0]  edv [3] = '{5'b11111, 5'b01111, 5'b00001};
    logic [19:0] b; logic [4:0] dv; logic ov; int lat;
    for (int i = 0; i < 3; i++) begin
      conv16(vin[i], b, dv, ov, lat);
      total++;
      if (b !== eb[i] || dv !== edv[i] || ov !== 1'b0 || lat != 16) begin
        bad++;
        $display("[TB] FAIL wide v=%0d got bcd=%h dv=%b ov=%b lat=%0d exp bcd=%h dv=%b ov=0 lat=16",
                 vin[i], b, dv, ov, lat, eb[i], edv[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [11:0] b3, e3; logic [2:0] dv3, edv3;
    logic [7:0]  b2, e2; logic [1:0] dv2, edv2;
    logic ov, eov; int lat, nb;
    for (int v = 0; v < 256; v++) begin
      e3 = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      edv3 = (v >= 100) ? 3'b111 : (v >= 10) ? 3'b011 : 3'b001;
      conv8(8'(v), b3, dv3, ov, lat, nb);
      total++;
      if (b3 !== e3 || dv3 !== edv3 || ov !== 1'b0 || lat != 8) begin
        bad++;
        $display("[TB] FAIL sweep3 v=%0d got %h/%b/%b lat=%0d exp %h/%b/0 lat=8", v, b3, dv3, ov, lat, e3, edv3);
      end
    end
    for (int v = 0; v < 256; v++) begin
      e2 = {4'((v / 10) % 10), 4'(v % 10)};
      edv2 = (((v / 10) % 10) != 0) ? 2'b11 : 2'b01;
      eov = (v >= 100);
      conv2(8'(v), b2, dv2, ov, lat);
      total++;
      if (b2 !== e2 || dv2 !== edv2 || ov !== eov || lat != 8) begin
        bad++;
        $display("[TB] FAIL sweep2 v=%0d got %h/%b/%b lat=%0d exp %h/%b/%b lat=8", v, b2, dv2, ov, lat, e2, edv2, eov);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_wide();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
